// File: rtl/sym_cn_rank_lut_pkg.sv
// Shared sizing for the check-node rank LUT core.
// Holds the default geometry and the page-width derivation.
package sym_cn_rank_lut_pkg;

  localparam int LUT_PORT_SIZE_DEF   = 2;
  localparam int ENTRY_ADDR_DEF      = 4;
  localparam int MULTI_FRAME_NUM_DEF = 2;
  localparam int NUM_PORTS           = 4;

  function automatic int page_width(input int entry_addr, input int frames);
    return entry_addr - $clog2(frames);
  endfunction

  localparam int PAGE_W_DEF = page_width(ENTRY_ADDR_DEF, MULTI_FRAME_NUM_DEF);

endpackage

// File: rtl/sym_cn_rank_lut_if.sv
// Port bundle of the CN rank LUT: four read ports, frame select and the
// dual-bank table-update port.
interface sym_cn_rank_lut_if #(
  parameter int LUT_PORT_SIZE = sym_cn_rank_lut_pkg::LUT_PORT_SIZE_DEF,
  parameter int PAGE_W        = sym_cn_rank_lut_pkg::PAGE_W_DEF
);
  logic [LUT_PORT_SIZE-1:0] y0_in_A, y0_in_B, y0_in_C, y0_in_D;
  logic [LUT_PORT_SIZE-1:0] y1_in_A, y1_in_B, y1_in_C, y1_in_D;
  logic                     read_addr_offset;
  logic [LUT_PORT_SIZE-1:0] lut_data_A, lut_data_B, lut_data_C, lut_data_D;
  logic                     read_addr_offset_out;
  logic [LUT_PORT_SIZE-1:0] lut_in_bank0, lut_in_bank1;
  logic [PAGE_W-1:0]        page_write_addr;
  logic                     write_addr_offset;
  logic                     we;

  modport master (
    output y0_in_A, y0_in_B, y0_in_C, y0_in_D,
    output y1_in_A, y1_in_B, y1_in_C, y1_in_D,
    output read_addr_offset,
    output lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we,
    input  lut_data_A, lut_data_B, lut_data_C, lut_data_D,
    input  read_addr_offset_out
  );

  modport slave (
    input  y0_in_A, y0_in_B, y0_in_C, y0_in_D,
    input  y1_in_A, y1_in_B, y1_in_C, y1_in_D,
    input  read_addr_offset,
    input  lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we,
    output lut_data_A, lut_data_B, lut_data_C, lut_data_D,
    output read_addr_offset_out
  );
endinterface

// File: rtl/sym_cn_rank_lut_cn_rank_mem.sv
// Dual-bank, two-frame rank memory: four asynchronous read ports and one
// write port that updates the same word of both banks together.
module cn_rank_mem
  import sym_cn_rank_lut_pkg::*;
#(
  parameter int LUT_PORT_SIZE = LUT_PORT_SIZE_DEF,
  parameter int ENTRY_ADDR    = ENTRY_ADDR_DEF,
  parameter int PAGE_W        = PAGE_W_DEF
) (
  input  logic                                    sys_clk,
  input  logic                                    rstn,
  input  logic                                    we,
  input  logic                                    wr_offset,
  input  logic [PAGE_W-1:0]                       wr_page,
  input  logic [LUT_PORT_SIZE-1:0]                wr_data0,
  input  logic [LUT_PORT_SIZE-1:0]                wr_data1,
  input  logic                                    rd_offset,
  input  logic [NUM_PORTS-1:0]                    rd_bank,
  input  logic [NUM_PORTS-1:0][PAGE_W-1:0]        rd_page,
  output logic [NUM_PORTS-1:0][LUT_PORT_SIZE-1:0] rd_data
);

  localparam int DEPTH = 2 ** ENTRY_ADDR;

  logic [LUT_PORT_SIZE-1:0] bank0 [DEPTH];
  logic [LUT_PORT_SIZE-1:0] bank1 [DEPTH];

  // Distributed RAM: contents survive reset, but updates are blocked while it is held.
  always_ff @(posedge sys_clk) begin
    if (rstn && we) begin
      bank0[{wr_offset, wr_page}] <= wr_data0;
      bank1[{wr_offset, wr_page}] <= wr_data1;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    logic [ENTRY_ADDR-1:0] addr;
    assign addr       = {rd_offset, rd_page[p]};
    assign rd_data[p] = rd_bank[p] ? bank1[addr] : bank0[addr];
  end

endmodule

// File: rtl/sym_cn_rank_lut.sv
// Check-node rank LUT core: folds each {y0,y1} pair into a bank/page address,
// reads the rank memory and registers the four results.
module sym_cn_rank_lut
  import sym_cn_rank_lut_pkg::*;
#(
  parameter int LUT_PORT_SIZE   = LUT_PORT_SIZE_DEF,
  parameter int ENTRY_ADDR      = ENTRY_ADDR_DEF,
  parameter int MULTI_FRAME_NUM = MULTI_FRAME_NUM_DEF
) (
  input  logic             sys_clk,
  input  logic             rstn,
  sym_cn_rank_lut_if.slave bus
);

  localparam int PAGE_W = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM);

  if (2 * LUT_PORT_SIZE != PAGE_W + 1) begin : g_bad_geometry
    $error("sym_cn_rank_lut: 2*LUT_PORT_SIZE must equal PAGE_W+1");
  end
  if (MULTI_FRAME_NUM != 2) begin : g_bad_frames
    $error("sym_cn_rank_lut: MULTI_FRAME_NUM must be 2");
  end

  logic [NUM_PORTS-1:0][LUT_PORT_SIZE-1:0] y0, y1, rd_data, lut_q;
  logic [NUM_PORTS-1:0]                    rd_bank;
  logic [NUM_PORTS-1:0][PAGE_W-1:0]        rd_page;
  logic                                    offset_q;

  assign y0 = {bus.y0_in_D, bus.y0_in_C, bus.y0_in_B, bus.y0_in_A};
  assign y1 = {bus.y1_in_D, bus.y1_in_C, bus.y1_in_B, bus.y1_in_A};

  // Entry index {y0,y1}: its LSB picks the bank, the remaining bits form the page.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_addr
    logic [2*LUT_PORT_SIZE-1:0] entry;
    assign entry      = {y0[p], y1[p]};
    assign rd_bank[p] = entry[0];
    assign rd_page[p] = entry[2*LUT_PORT_SIZE-1:1];
  end

  cn_rank_mem #(
    .LUT_PORT_SIZE (LUT_PORT_SIZE),
    .ENTRY_ADDR    (ENTRY_ADDR),
    .PAGE_W        (PAGE_W)
  ) u_mem (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .we        (bus.we),
    .wr_offset (bus.write_addr_offset),
    .wr_page   (bus.page_write_addr),
    .wr_data0  (bus.lut_in_bank0),
    .wr_data1  (bus.lut_in_bank1),
    .rd_offset (bus.read_addr_offset),
    .rd_bank   (rd_bank),
    .rd_page   (rd_page),
    .rd_data   (rd_data)
  );

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      lut_q    <= '0;
      offset_q <= 1'b0;
    end else begin
      lut_q    <= rd_data;
      offset_q <= bus.read_addr_offset;
    end
  end

  assign bus.lut_data_A           = lut_q[0];
  assign bus.lut_data_B           = lut_q[1];
  assign bus.lut_data_C           = lut_q[2];
  assign bus.lut_data_D           = lut_q[3];
  assign bus.read_addr_offset_out = offset_q;

endmodule

// File: tb/tb_sym_cn_rank_lut.sv
// Scoreboard bench for sym_cn_rank_lut: stimulus pushes expected read results,
// a monitor pops and compares them one cycle after each issued read.
module tb_sym_cn_rank_lut;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sym_cn_rank_lut_if #(.LUT_PORT_SIZE(2), .PAGE_W(3)) bus ();

  sym_cn_rank_lut dut (
    .sys_clk (clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0] a, b, c, d;
    logic       off;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] m0 [16];
  logic [1:0] m1 [16];
  logic       rd_valid = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] model_rd(input logic [1:0] y0, input logic [1:0] y1,
                                          input logic off);
    logic [3:0] a;
    a = {off, y0, y1[1]};
    return y1[0] ? m1[a] : m0[a];
  endfunction

  // y0s/y1s pack ports A..D as [1:0]..[7:6]
  task automatic step(input logic [7:0] y0s, input logic [7:0] y1s, input logic off,
                      input logic rd, input logic wr, input logic [2:0] wp, input logic wo,
                      input logic [1:0] d0, input logic [1:0] d1);
    exp_t e;
    @(negedge clk);
    bus.y0_in_A = y0s[1:0]; bus.y0_in_B = y0s[3:2]; bus.y0_in_C = y0s[5:4]; bus.y0_in_D = y0s[7:6];
    bus.y1_in_A = y1s[1:0]; bus.y1_in_B = y1s[3:2]; bus.y1_in_C = y1s[5:4]; bus.y1_in_D = y1s[7:6];
    bus.read_addr_offset  = off;
    bus.we                = wr;
    bus.page_write_addr   = wp;
    bus.write_addr_offset = wo;
    bus.lut_in_bank0      = d0;
    bus.lut_in_bank1      = d1;
    rd_valid              = rd;
    if (rd) begin
      e.a   = model_rd(y0s[1:0], y1s[1:0], off);
      e.b   = model_rd(y0s[3:2], y1s[3:2], off);
      e.c   = model_rd(y0s[5:4], y1s[5:4], off);
      e.d   = model_rd(y0s[7:6], y1s[7:6], off);
      e.off = off;
      sb.push_back(e);
    end
    // read-during-write: expectation above uses the old word
    if (wr && rstn) begin
      m0[{wo, wp}] = d0;
      m1[{wo, wp}] = d1;
    end
  endtask

  task automatic rd1(input logic [1:0] y0, input logic [1:0] y1, input logic off);
    step({4{y0}}, {4{y1}}, off, 1'b1, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic wr1(input logic [2:0] wp, input logic wo, input logic [1:0] d0,
                     input logic [1:0] d1);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, wp, wo, d0, d1);
  endtask

  task automatic idle();
    @(negedge clk);
    rd_valid = 1'b0;
    bus.we   = 1'b0;
  endtask

  // Monitor: a read issued before an edge is checked just after that edge.
  initial begin
    exp_t e;
    logic v;
    forever begin
      @(posedge clk);
      v = rd_valid;
      #1;
      if (v) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_underflow: output with no expectation at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("lut_data_A", bus.lut_data_A, e.a);
          check("lut_data_B", bus.lut_data_B, e.b);
          check("lut_data_C", bus.lut_data_C, e.c);
          check("lut_data_D", bus.lut_data_D, e.d);
          check("offset_out", {1'b0, bus.read_addr_offset_out}, {1'b0, e.off});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a;
    logic [3:0] ea, eb, ec, ed;
    int wait_cnt;
    for (int i = 0; i < 16; i++) begin m0[i] = 2'b00; m1[i] = 2'b00; end

    // reset with arbitrary inputs
    bus.y0_in_A = 2'b11; bus.y0_in_B = 2'b10; bus.y0_in_C = 2'b01; bus.y0_in_D = 2'b11;
    bus.y1_in_A = 2'b01; bus.y1_in_B = 2'b11; bus.y1_in_C = 2'b10; bus.y1_in_D = 2'b01;
    bus.read_addr_offset = 1'b1; bus.we = 1'b1; bus.page_write_addr = 3'd7;
    bus.write_addr_offset = 1'b1; bus.lut_in_bank0 = 2'b11; bus.lut_in_bank1 = 2'b11;
    #1;
    check("reset_A", bus.lut_data_A, 2'b00);
    check("reset_offset", {1'b0, bus.read_addr_offset_out}, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_B", bus.lut_data_B, 2'b00);
    check("reset_hold_D", bus.lut_data_D, 2'b00);
    idle();
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      a = i[3:0];
      wr1(a[2:0], a[3], 2'b00, 2'b00);
    end

    // write then read, page 5 frame 0
    wr1(3'd5, 1'b0, 2'b01, 2'b11);
    rd1(2'b10, 2'b11, 1'b0);
    rd1(2'b10, 2'b10, 1'b0);

    // frame isolation
    wr1(3'd5, 1'b1, 2'b10, 2'b00);
    rd1(2'b10, 2'b11, 1'b0);
    rd1(2'b10, 2'b10, 1'b0);
    rd1(2'b10, 2'b11, 1'b1);
    rd1(2'b10, 2'b10, 1'b1);
    rd1(2'b10, 2'b10, 1'b0);

    // fill all 32 words with varied patterns
    for (int i = 0; i < 16; i++) begin
      a = i[3:0];
      wr1(a[2:0], a[3], a[1:0] ^ a[3:2], ~a[1:0] + {1'b0, a[2]});
    end
    for (int off = 0; off < 2; off++) begin
      for (int c = 0; c < 4; c++) begin
        ea = 4'(c * 4); eb = 4'(c * 4 + 1); ec = 4'(c * 4 + 2); ed = 4'(c * 4 + 3);
        step({ed[3:2], ec[3:2], eb[3:2], ea[3:2]}, {ed[1:0], ec[1:0], eb[1:0], ea[1:0]},
             off[0], 1'b1, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00);
      end
    end
    rd1(2'b01, 2'b10, 1'b1);
    step({2'b11, 2'b11, 2'b00, 2'b00}, {2'b00, 2'b00, 2'b11, 2'b11}, 1'b0,
         1'b1, 1'b0, 3'd0, 1'b0, 2'b00, 2'b00);

    // read-during-write on page 2 frame 0
    wr1(3'd2, 1'b0, 2'b00, 2'b00);
    step(8'b01010101, 8'b00000000, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 2'b10, 2'b01);
    rd1(2'b01, 2'b00, 1'b0);
    rd1(2'b01, 2'b01, 1'b0);

    // we=0 leaves memory untouched
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 2'b11, 2'b11);
    rd1(2'b01, 2'b00, 1'b0);
    rd1(2'b01, 2'b01, 1'b0);

    // asynchronous reset mid-stream, write blocked while held
    rd1(2'b01, 2'b00, 1'b0);
    idle();
    @(posedge clk);
    #1;
    check("pre_reset_A", bus.lut_data_A, 2'b10);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_A", bus.lut_data_A, 2'b00);
    check("async_reset_C", bus.lut_data_C, 2'b00);
    wr1(3'd2, 1'b0, 2'b11, 2'b11);
    idle();
    @(posedge clk);
    #1;
    check("reset_write_held_A", bus.lut_data_A, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
    rd1(2'b01, 2'b00, 1'b0);
    rd1(2'b01, 2'b01, 1'b0);
    idle();

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    repeat (2) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
